// File: rtl/alu_req_ctrl.sv
// Request/response sequencer in front of a fixed-latency ALU.
// Holds one command at a time and returns the captured result and flags.
module alu_req_ctrl #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [3:0]   cmd_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_s,
    input  logic [N-1:0] alu_q,
    input  logic         alu_ne,
    input  logic         alu_z,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_q,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic         busy,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       accept;
    logic       op_legal;
    logic       div_zero;

    assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
    assign op_legal = (cmd_op <= 4'd9);
    assign div_zero = ((alu_s == 4'd3) || (alu_s == 4'd4)) && (alu_b == '0);

    // cmd_ready and busy are registered so rsp_ready never reaches cmd_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (op_legal) begin
                            alu_a <= cmd_a;
                            alu_b <= cmd_b;
                            alu_s <= cmd_op;
                            cnt   <= 4'(LAT - 1);
                            state <= WAIT;
                        end else begin
                            rsp_q     <= '0;
                            rsp_flags <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_q     <= alu_q;
                        rsp_flags <= {alu_ne, alu_z, alu_v, alu_c};
                        rsp_err   <= div_zero;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_req_ctrl.md
ALU_REQ_CTRL -- requirements
Module: alu_req_ctrl

Interface
REQ-001 Parameter N, default 4: operand/result width in bits.
REQ-002 Parameter LAT, default 1, legal range 1..15: cycles from command acceptance to ALU result capture.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  requester presents a command.
REQ-006 cmd_ready  out  1  block can accept a command.
REQ-007 cmd_a, cmd_b  in  N each  operands.
REQ-008 cmd_op  in  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 sll, 9 srl.
REQ-009 alu_a, alu_b  out  N each  registered operands driven to ALU A, B.
REQ-010 alu_s  out  4  registered opcode driven to ALU S.
REQ-011 alu_q  in  N  ALU result Q.
REQ-012 alu_ne, alu_z, alu_v, alu_c  in  1 each  ALU flags.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_q  out  N  captured result.
REQ-016 rsp_flags  out  4  captured flags {Ne,Z,V,C}, bit 3 = Ne.
REQ-017 rsp_err  out  1  illegal opcode or divide/modulo by zero.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 op_count  out  8  completed-response counter.

Function
REQ-020 FSM states IDLE, WAIT, RESP; exactly one command outstanding at a time.
REQ-021 cmd_ready SHALL be 1 only in IDLE; command accepted on an edge with cmd_valid && cmd_ready.
REQ-022 On acceptance of a legal opcode (0..9): alu_a/alu_b/alu_s load cmd_a/cmd_b/cmd_op on that edge; wait counter loads LAT-1; next state WAIT.
REQ-023 alu_a, alu_b, alu_s SHALL hold stable from acceptance until the next acceptance.
REQ-024 WAIT: counter decrements each edge; on the edge where counter is 0, capture alu_q into rsp_q and flags into rsp_flags; set rsp_valid; next state RESP. Capture edge is exactly LAT edges after acceptance edge.
REQ-025 rsp_err SHALL be set at capture when alu_s is 3 or 4 and alu_b == 0; rsp_q/rsp_flags still capture ALU outputs.
REQ-026 Illegal opcode (10..15) on acceptance: ALU registers not loaded; on the same edge rsp_q=0, rsp_flags=0, rsp_err=1, rsp_valid=1; next state RESP (WAIT skipped).
REQ-027 RESP: rsp_valid, rsp_q, rsp_flags, rsp_err held stable until rsp_valid && rsp_ready on an edge; then rsp_valid=0, rsp_err=0, next state IDLE.
REQ-028 rsp_ready already high on entry to RESP: handshake completes on first RESP edge; no combinational path from rsp_ready to cmd_ready (cmd_ready returns one cycle later).
REQ-029 op_count increments by 1 on every completed response handshake, including error responses; wraps 255 -> 0.
REQ-030 cmd_valid while not in IDLE SHALL be ignored; cmd_* values need not be held by the block.
REQ-031 rsp_ready outside RESP SHALL have no effect.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, cmd_ready=0, alu_a=0, alu_b=0, alu_s=0, rsp_valid=0, rsp_q=0, rsp_flags=0, rsp_err=0, busy=0, op_count=0, counter=0.
REQ-033 cmd_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-034 Reset asserted in WAIT or RESP SHALL abort the operation; no response is produced and op_count is not incremented.

Verification (N=4, ALU replaced by a stub returning programmable alu_q/flags)
REQ-035 LAT=1, cmd {a=5,b=3,op=0}, stub alu_q=8, flags=0000, rsp_ready=1 -> alu_a=5, alu_b=3, alu_s=0 after accept edge; rsp_valid one edge later with rsp_q=8, rsp_err=0; op_count=1.
REQ-036 LAT=3, cmd op=2, stub alu_q=4'hA, flags=1000 -> rsp_valid exactly 3 edges after acceptance, rsp_flags=1000, busy=1 throughout WAIT/RESP.
REQ-037 cmd {a=7,b=0,op=3} -> rsp_err=1, rsp_q equals stub alu_q; cmd op=12 -> rsp_valid on the accept edge, rsp_q=0, rsp_err=1, alu_s unchanged.
REQ-038 rsp_ready held 0 for 5 cycles in RESP with a second cmd_valid asserted -> outputs stable, cmd_ready=0, second command not accepted until one cycle after handshake.
REQ-039 256 back-to-back handshakes -> op_count wraps to 0; rst_n pulsed low mid-WAIT -> all outputs zero immediately, no rsp_valid, cmd_ready=1 one edge after release.
